// File: rtl/uart_pkg.sv
// Shared definitions for io_uart: register offsets, STATUS bit positions and the
// serial FSM state encoding used by both the transmitter and the receiver.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_TX_BUSY  = 2;
  localparam int unsigned ST_RX_VALID = 3;
  localparam int unsigned ST_RX_OVR   = 4;
  localparam int unsigned ST_RX_FERR  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } ser_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with 2^FIFO_AW entries; a push while full is dropped even when a
// pop happens in the same cycle. A count register separates full from empty.
module uart_tx_fifo #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  logic [7:0]         mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               do_push, do_pop;

  assign full    = (count_q == (FIFO_AW + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (FIFO_AW + 1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (FIFO_AW + 1)'(1);
    end
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped UART: TX FIFO + serializer, register decode, and a single-byte receiver
// that is built only when UART_RX_EN is defined.
module io_uart import uart_pkg::*; #(
  parameter int unsigned DEFAULT_DIV = 434,
  parameter int unsigned FIFO_AW     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr_i,
  input  logic        io_ce_i,
  input  logic        io_we_i,
  input  logic [31:0] io_wdata_i,
  output logic [31:0] io_rdata_o,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  logic [1:0]  reg_sel;
  logic        wr_en, rd_en;
  logic [15:0] baud_q;

  assign reg_sel = io_addr_i[3:2];
  assign wr_en   = io_ce_i & io_we_i;
  assign rd_en   = io_ce_i & ~io_we_i;

  logic unused_bits;
  assign unused_bits = ^{io_addr_i[31:4], io_addr_i[1:0], io_wdata_i[31:16]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q <= 16'(DEFAULT_DIV);
    end else if (wr_en && reg_sel == REG_BAUD) begin
      baud_q <= (io_wdata_i[15:0] < 16'd2) ? 16'd2 : io_wdata_i[15:0];
    end
  end

  // Transmit path
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  ser_state_e  tx_state_q;
  logic [15:0] tx_div_q, tx_cnt_q;
  logic [7:0]  tx_shift_q;
  logic [2:0]  tx_idx_q;
  logic        tx_tick;

  assign fifo_push = wr_en && reg_sel == REG_DATA;
  assign tx_tick   = (tx_cnt_q == 16'd0);
  assign fifo_pop  = !fifo_empty && (tx_state_q == StIdle || (tx_state_q == StStop && tx_tick));

  uart_tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (io_wdata_i[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= StIdle;
      tx_div_q   <= 16'(DEFAULT_DIV);
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
      uart_txd   <= 1'b1;
    end else begin
      unique case (tx_state_q)
        StIdle: begin
          if (fifo_pop) begin
            tx_state_q <= StStart;
            tx_shift_q <= fifo_rdata;
            tx_div_q   <= baud_q;
            tx_cnt_q   <= baud_q - 16'd1;
            uart_txd   <= 1'b0;
          end
        end
        StStart: begin
          if (tx_tick) begin
            tx_state_q <= StData;
            tx_idx_q   <= '0;
            tx_cnt_q   <= tx_div_q - 16'd1;
            uart_txd   <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        StData: begin
          if (tx_tick) begin
            tx_cnt_q <= tx_div_q - 16'd1;
            if (tx_idx_q == 3'd7) begin
              tx_state_q <= StStop;
              uart_txd   <= 1'b1;
            end else begin
              tx_idx_q   <= tx_idx_q + 3'd1;
              uart_txd   <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        StStop: begin
          if (tx_tick) begin
            if (fifo_pop) begin
              // Chain straight into the next start bit so back-to-back bytes have no gap.
              tx_state_q <= StStart;
              tx_shift_q <= fifo_rdata;
              tx_div_q   <= baud_q;
              tx_cnt_q   <= baud_q - 16'd1;
              uart_txd   <= 1'b0;
            end else begin
              tx_state_q <= StIdle;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
      endcase
    end
  end

  // Receive path
  logic [7:0] rx_byte;
  logic       rx_valid, rx_ovr, rx_ferr;

`ifdef UART_RX_EN
  logic [1:0]  rx_sync_q;
  logic        rx_prev_q, rx_in, rx_rd;
  ser_state_e  rx_state_q;
  logic [15:0] rx_div_q, rx_cnt_q;
  logic [7:0]  rx_shift_q, rx_byte_q;
  logic [2:0]  rx_idx_q;
  logic        rx_valid_q, rx_ovr_q, rx_ferr_q;

  assign rx_in    = rx_sync_q[1];
  assign rx_rd    = rd_en && reg_sel == REG_DATA;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign rx_ovr   = rx_ovr_q;
  assign rx_ferr  = rx_ferr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_div_q   <= 16'(DEFAULT_DIV);
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_idx_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rxd};
      rx_prev_q <= rx_in;
      if (rx_rd) begin
        rx_valid_q <= 1'b0;
        rx_ovr_q   <= 1'b0;
        rx_ferr_q  <= 1'b0;
      end
      unique case (rx_state_q)
        StIdle: begin
          if (rx_prev_q && !rx_in) begin
            rx_state_q <= StStart;
            rx_div_q   <= baud_q;
            rx_cnt_q   <= (baud_q >> 1) - 16'd1;
          end
        end
        StStart: begin
          if (rx_cnt_q == 16'd0) begin
            if (rx_in) begin
              rx_state_q <= StIdle;
            end else begin
              rx_state_q <= StData;
              rx_idx_q   <= '0;
              rx_cnt_q   <= rx_div_q - 16'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        StData: begin
          if (rx_cnt_q == 16'd0) begin
            rx_shift_q <= {rx_in, rx_shift_q[7:1]};
            rx_cnt_q   <= rx_div_q - 16'd1;
            if (rx_idx_q == 3'd7) rx_state_q <= StStop;
            else                  rx_idx_q   <= rx_idx_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        StStop: begin
          if (rx_cnt_q == 16'd0) begin
            rx_state_q <= StIdle;
            // Completion beats a coincident DATA read; a byte consumed that cycle is no overrun.
            if (rx_in) begin
              rx_byte_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
              rx_ovr_q   <= (rx_valid_q || rx_ovr_q) && !rx_rd;
            end else begin
              rx_ferr_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
      endcase
    end
  end
`else
  logic unused_rxd;
  assign unused_rxd = uart_rxd;
  assign rx_byte    = '0;
  assign rx_valid   = 1'b0;
  assign rx_ovr     = 1'b0;
  assign rx_ferr    = 1'b0;
`endif

  logic [5:0] status;

  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = fifo_full;
    status[ST_TX_EMPTY] = fifo_empty;
    status[ST_TX_BUSY]  = (tx_state_q != StIdle);
    status[ST_RX_VALID] = rx_valid;
    status[ST_RX_OVR]   = rx_ovr;
    status[ST_RX_FERR]  = rx_ferr;
  end

  always_comb begin
    io_rdata_o = '0;
    if (rd_en) begin
      case (reg_sel)
        REG_DATA:   io_rdata_o = {24'b0, rx_byte};
        REG_STATUS: io_rdata_o = {26'b0, status};
        REG_BAUD:   io_rdata_o = {16'b0, baud_q};
        default:    io_rdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart: register access, TX waveforms against a frame model,
// FIFO overflow, asynchronous reset, and (with UART_RX_EN) the receiver.
module tb_io_uart;

  localparam int unsigned DefDiv = 434;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_addr_i = '0;
  logic        io_ce_i = 1'b0;
  logic        io_we_i = 1'b0;
  logic [31:0] io_wdata_i = '0;
  logic [31:0] io_rdata_o;
  logic        uart_txd;
  logic        uart_rxd = 1'b1;

  always #5 clk = ~clk;

  io_uart #(
    .DEFAULT_DIV (DefDiv),
    .FIFO_AW     (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .io_addr_i  (io_addr_i),
    .io_ce_i    (io_ce_i),
    .io_we_i    (io_we_i),
    .io_wdata_i (io_wdata_i),
    .io_rdata_o (io_rdata_o),
    .uart_txd   (uart_txd),
    .uart_rxd   (uart_rxd)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  bit   cap_on = 1'b0;
  logic txq[$];
  logic expq[$];
  logic [7:0] tx_bytes [16];

  always @(negedge clk) if (cap_on) txq.push_back(uart_txd);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus tasks start and end at posedge+1.
  task automatic bus_write(input logic [1:0] sel, input logic [31:0] data);
    io_addr_i  = {28'b0, sel, 2'b00};
    io_wdata_i = data;
    io_ce_i    = 1'b1;
    io_we_i    = 1'b1;
    @(posedge clk);
    #1;
    io_ce_i = 1'b0;
    io_we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [31:0] data);
    io_addr_i = {28'b0, sel, 2'b00};
    io_ce_i   = 1'b1;
    io_we_i   = 1'b0;
    #2;
    data = io_rdata_o;
    @(posedge clk);
    #1;
    io_ce_i = 1'b0;
  endtask

  // Ideal line: two idle samples, then 10-bit frames at div samples per bit, then idle.
  function automatic void build_wave(input int unsigned div, input int nacc);
    logic [9:0] fr;
    expq.delete();
    expq.push_back(1'b1);
    expq.push_back(1'b1);
    for (int f = 0; f < nacc; f++) begin
      fr = {1'b1, tx_bytes[f], 1'b0};
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < int'(div); c++) expq.push_back(fr[b]);
    end
    for (int k = 0; k < 4; k++) expq.push_back(1'b1);
  endfunction

  task automatic run_tx(input string tag, input int unsigned div, input int n,
                        input bit chk_full);
    logic [31:0] rd;
    int          nacc;
    bus_write(2'd2, div);
    txq.delete();
    cap_on = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus_write(2'd0, {24'b0, tx_bytes[i]});
      if (chk_full && i == 8) begin
        bus_read(2'd1, rd);
        check({tag, "_status_full"}, rd, 32'h5);
      end
    end
    // Idle shifter takes the first byte at once, so 8 FIFO slots + 1 shifter accept 9 bytes.
    nacc = (n > 9) ? 9 : n;
    build_wave(div, nacc);
    while (txq.size() < expq.size()) @(negedge clk);
    cap_on = 1'b0;
    for (int i = 0; i < expq.size(); i++)
      check($sformatf("%s_txd[%0d]", tag, i), {31'b0, txq[i]}, {31'b0, expq[i]});
    @(posedge clk);
    #1;
    bus_read(2'd1, rd);
    check({tag, "_status_done"}, rd, 32'h2);
  endtask

`ifdef UART_RX_EN
  logic [7:0] exp_byte = '0;
  bit exp_valid = 0, exp_ovr = 0, exp_ferr = 0;

  task automatic rx_send(input logic [7:0] b, input bit stop, input int div);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rxd = fr[k];
      repeat (div) @(posedge clk);
      #1;
    end
    uart_rxd = 1'b1;
    repeat (2 * div) @(posedge clk);
    #1;
    if (stop) begin
      if (exp_valid) exp_ovr = 1'b1;
      exp_valid = 1'b1;
      exp_byte  = b;
    end else begin
      exp_ferr = 1'b1;
    end
  endtask

  task automatic rx_check_status(input string tag);
    logic [31:0] rd;
    bus_read(2'd1, rd);
    check(tag, rd, {26'b0, exp_ferr, exp_ovr, exp_valid, 3'b010});
  endtask

  task automatic rx_read_data(input string tag);
    logic [31:0] rd;
    bus_read(2'd0, rd);
    check(tag, rd, {24'b0, exp_byte});
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    exp_ferr  = 1'b0;
  endtask
`endif

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          n;
    int unsigned div;

    repeat (3) @(posedge clk);
    #1;
    check("txd_in_reset", {31'b0, uart_txd}, 32'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    bus_read(2'd1, rd); check("reset_status", rd, 32'h2);
    check("reset_txd", {31'b0, uart_txd}, 32'h1);
    bus_read(2'd2, rd); check("reset_baud", rd, DefDiv);
    bus_read(2'd0, rd); check("reset_data", rd, 32'h0);
    bus_read(2'd3, rd); check("reserved_read", rd, 32'h0);

    // Reads are masked while writing or deselected.
    io_addr_i = 32'h8; io_ce_i = 1'b1; io_we_i = 1'b1; io_wdata_i = 32'h0;
    #2; check("rdata_during_we", io_rdata_o, 32'h0);
    io_ce_i = 1'b0; io_we_i = 1'b0;
    #2; check("rdata_ce_low", io_rdata_o, 32'h0);
    @(posedge clk); #1;

    bus_write(2'd2, 32'h0);     bus_read(2'd2, rd); check("baud_clamp0", rd, 32'h2);
    bus_write(2'd2, 32'h1);     bus_read(2'd2, rd); check("baud_clamp1", rd, 32'h2);
    bus_write(2'd2, 32'h12345); bus_read(2'd2, rd); check("baud_16bit", rd, 32'h2345);
    bus_write(2'd3, 32'hFFFF);  bus_read(2'd2, rd); check("reserved_wr", rd, 32'h2345);
    bus_read(2'd1, rd); check("status_after_regs", rd, 32'h2);

    tx_bytes[0] = 8'hA5;
    run_tx("a5", 4, 1, 1'b0);

    for (int i = 0; i < 10; i++) tx_bytes[i] = 8'(i);
    run_tx("overflow", 2, 10, 1'b1);

    for (int r = 0; r < 4; r++) begin
      div = $urandom_range(2, 6);
      n   = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) tx_bytes[i] = 8'($urandom);
      run_tx($sformatf("rand%0d", r), div, n, 1'b0);
    end

    // Asynchronous reset in the middle of an all-zero frame.
    bus_write(2'd2, 32'h4);
    bus_write(2'd0, 32'h0);
    repeat (12) @(posedge clk);
    #2;
    check("midframe_low", {31'b0, uart_txd}, 32'h0);
    rst = 1'b1;
    #1;
    check("async_rst_txd", {31'b0, uart_txd}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_read(2'd1, rd); check("post_rst_status", rd, 32'h2);
    bus_read(2'd2, rd); check("post_rst_baud", rd, DefDiv);
    repeat (50) @(posedge clk);
    #1;
    check("post_rst_idle", {31'b0, uart_txd}, 32'h1);

`ifdef UART_RX_EN
    bus_write(2'd2, 32'd8);
    rx_send(8'h3C, 1'b1, 8);
    rx_check_status("rx_3c_status");
    rx_read_data("rx_3c_data");
    rx_check_status("rx_3c_cleared");
    rx_send(8'h81, 1'b1, 8);
    rx_send(8'h4E, 1'b1, 8);
    rx_check_status("rx_ovr_status");
    rx_read_data("rx_ovr_data");
    rx_check_status("rx_ovr_cleared");
    rx_send(8'h55, 1'b0, 8);
    rx_check_status("rx_ferr_status");
    rx_read_data("rx_ferr_data");
    rx_check_status("rx_ferr_cleared");
    for (int r = 0; r < 4; r++) begin
      rx_send(8'($urandom), ($urandom_range(0, 3) != 0), 8);
      rx_check_status($sformatf("rx_rand%0d_status", r));
      if ($urandom_range(0, 1) == 1) rx_read_data($sformatf("rx_rand%0d_data", r));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
